// File: rtl/row_window_fetcher_pkg.sv
// Shared defaults and FSM state type for the row window fetcher.
// Optional build macro used by this block: REPLICATE_BORDER_EN.
package rwf_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_ROWS  = 128;
    localparam int DEFAULT_AW    = 7;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } rwf_state_t;

endpackage

// File: rtl/row_window_shreg.sv
// Three-row window shift register (above/center/below) with border padding.
// REPLICATE_BORDER_EN selects edge-row replication instead of zero padding.
module row_window_shreg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fetch,
    input  logic             pad_shift,
    input  logic             first,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] above,
    output logic [WIDTH-1:0] center,
    output logic [WIDTH-1:0] below
);

    logic [WIDTH-1:0] top_pad;
    logic [WIDTH-1:0] bottom_pad;

    // The first fetch of a frame also seeds center, so it becomes row 0's above.
`ifdef REPLICATE_BORDER_EN
    assign top_pad    = rom_data;
    assign bottom_pad = below;
`else
    assign top_pad    = '0;
    assign bottom_pad = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            above  <= '0;
            center <= '0;
            below  <= '0;
        end else if (fetch) begin
            above  <= center;
            center <= first ? top_pad : below;
            below  <= rom_data;
        end else if (pad_shift) begin
            above  <= center;
            center <= below;
            below  <= bottom_pad;
        end
    end

endmodule

// File: rtl/row_window_fetcher.sv
// Walks the ROM image row by row and streams 3-row windows to the edge stage.
// REPLICATE_BORDER_EN (in row_window_shreg) replicates border rows as padding.
module row_window_fetcher
    import rwf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ROWS  = DEFAULT_ROWS,
    parameter int AW    = DEFAULT_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             rom_rqst,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [WIDTH-1:0] win_above,
    output logic [WIDTH-1:0] win_center,
    output logic [WIDTH-1:0] win_below,
    output logic [AW-1:0]    win_row,
    output logic             busy,
    output logic             done
);

    localparam logic [AW:0]   ROW_LIMIT = (AW+1)'(ROWS);
    localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);

    rwf_state_t  state;
    rwf_state_t  next_state;
    logic [AW:0] fetch_addr;
    logic        more_rows;
    logic        handshake;
    logic        last_row;
    logic        clear;
    logic        fetch;
    logic        pad_shift;
    logic        first;

    // fetch_addr saturates at ROWS, one bit wider than the ROM address.
    assign more_rows = (fetch_addr < ROW_LIMIT);
    assign handshake = (state == STREAM) && win_ready;
    assign last_row  = (win_row == LAST_ROW);
    assign clear     = (state == IDLE) && start;
    assign first     = (state == PRIME) && (fetch_addr == '0);
    assign fetch     = (state == PRIME) || (handshake && !last_row && more_rows);
    assign pad_shift = handshake && !last_row && !more_rows;
    assign rom_addr  = fetch_addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PRIME;
            PRIME:   if (fetch_addr == (AW+1)'(1)) next_state = STREAM;
            STREAM:  if (handshake && last_row) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        win_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rom_rqst  = 1'b0;
        case (state)
            PRIME: begin
                busy     = 1'b1;
                rom_rqst = 1'b1;
            end
            STREAM: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                rom_rqst  = more_rows;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The final handshake leaves the window untouched, so win_row tops out at ROWS-1.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fetch_addr <= '0;
            win_row    <= '0;
        end else begin
            if (fetch) begin
                fetch_addr <= fetch_addr + (AW+1)'(1);
            end
            if (handshake && !last_row) begin
                win_row <= win_row + AW'(1);
            end
        end
    end

    row_window_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .fetch    (fetch),
        .pad_shift(pad_shift),
        .first    (first),
        .rom_data (rom_data),
        .above    (win_above),
        .center   (win_center),
        .below    (win_below)
    );

endmodule

// File: tb/tb_row_window_fetcher.sv
// Directed self-checking bench for row_window_fetcher (default and ROWS=2 builds).
// Honours REPLICATE_BORDER_EN when computing expected border pads.
module tb_row_window_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  rom_addr;
    logic [63:0] rom_data;
    logic        rom_rqst;
    logic        win_valid;
    logic        win_ready;
    logic [63:0] win_above;
    logic [63:0] win_center;
    logic [63:0] win_below;
    logic [6:0]  win_row;
    logic        busy;
    logic        done;

    logic        start2;
    logic [0:0]  rom_addr2;
    logic [63:0] rom_data2;
    logic        rom_rqst2;
    logic        win_valid2;
    logic        win_ready2;
    logic [63:0] win_above2;
    logic [63:0] win_center2;
    logic [63:0] win_below2;
    logic [0:0]  win_row2;
    logic        busy2;
    logic        done2;

    int checks   = 0;
    int failures = 0;
    int rqst_cnt = 0;
    int done_cnt = 0;
    int snap_rqst;
    int snap_done;

    always #5 clk = ~clk;

    assign rom_data  = {8{{1'b0, rom_addr}}};
    assign rom_data2 = {8{{7'b0, rom_addr2}}};

    always @(posedge clk) begin
        if (rom_rqst) rqst_cnt++;
        if (done) done_cnt++;
    end

    row_window_fetcher dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_rqst  (rom_rqst),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_above (win_above),
        .win_center(win_center),
        .win_below (win_below),
        .win_row   (win_row),
        .busy      (busy),
        .done      (done)
    );

    row_window_fetcher #(.WIDTH(64), .ROWS(2), .AW(1)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .rom_addr  (rom_addr2),
        .rom_data  (rom_data2),
        .rom_rqst  (rom_rqst2),
        .win_valid (win_valid2),
        .win_ready (win_ready2),
        .win_above (win_above2),
        .win_center(win_center2),
        .win_below (win_below2),
        .win_row   (win_row2),
        .busy      (busy2),
        .done      (done2)
    );

    function automatic logic [63:0] rowv(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8{b}};
    endfunction

    function automatic logic [63:0] exp_above(input int i);
        if (i == 0) begin
`ifdef REPLICATE_BORDER_EN
            return rowv(0);
`else
            return 64'h0;
`endif
        end
        return rowv(i - 1);
    endfunction

    function automatic logic [63:0] exp_below(input int i, input int rows);
        if (i == rows - 1) begin
`ifdef REPLICATE_BORDER_EN
            return rowv(rows - 1);
`else
            return 64'h0;
`endif
        end
        return rowv(i + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("prime_busy", 64'(busy), 64'd1);
        chk("prime_rqst", 64'(rom_rqst), 64'd1);
        chk("prime_valid", 64'(win_valid), 64'd0);
        chk("prime_addr0", 64'(rom_addr), 64'd0);
        tick();
        chk("prime_addr1", 64'(rom_addr), 64'd1);
        chk("prime_valid2", 64'(win_valid), 64'd0);
        tick();
    endtask

    task automatic run_stream(input int stop_at, input int stall_at, input int pulse_at);
        for (int i = 0; i <= stop_at; i++) begin
            chk("win_valid", 64'(win_valid), 64'd1);
            chk("win_row", 64'(win_row), 64'(i));
            chk("win_center", win_center, rowv(i));
            chk("win_above", win_above, exp_above(i));
            chk("win_below", win_below, exp_below(i, 128));
            if (i == stall_at) begin
                chk("stall_addr", 64'(rom_addr), 64'(i + 2));
                win_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall_row", 64'(win_row), 64'(i));
                    chk("stall_center", win_center, rowv(i));
                    chk("stall_above", win_above, exp_above(i));
                    chk("stall_below", win_below, exp_below(i, 128));
                    chk("stall_addr_hold", 64'(rom_addr), 64'(i + 2));
                    chk("stall_valid", 64'(win_valid), 64'd1);
                end
                win_ready = 1'b1;
            end
            if (i == stop_at) break;
            if (i == pulse_at) start = 1'b1;
            tick();
            if (i == pulse_at) start = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        win_ready  = 1'b1;
        start2     = 1'b0;
        win_ready2 = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(win_valid), 64'd0);
        chk("rst_rqst", 64'(rom_rqst), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_row", 64'(win_row), 64'd0);
        chk("rst_center", win_center, 64'd0);
        rst = 1'b0;
        tick();

        // Pass 1: stall at row 10, ignored start pulse at row 40.
        snap_done = done_cnt;
        start_pass();
        run_stream(127, 10, 40);
        tick();
        chk("p1_done_pulse", 64'(done), 64'd1);
        chk("p1_done_valid", 64'(win_valid), 64'd0);
        tick();
        chk("p1_done_low", 64'(done), 64'd0);
        chk("p1_idle_busy", 64'(busy), 64'd0);
        chk("p1_done_count", 64'(done_cnt - snap_done), 64'd1);

        // Pass 2: start held high throughout; rom_rqst cycle count.
        snap_rqst = rqst_cnt;
        start = 1'b1;
        tick();
        chk("p2_prime_busy", 64'(busy), 64'd1);
        tick();
        tick();
        run_stream(127, -1, -1);
        tick();
        chk("p2_done_pulse", 64'(done), 64'd1);
        chk("p2_rqst_cycles", 64'(rqst_cnt - snap_rqst), 64'd128);
        tick();
        chk("p2_idle_busy", 64'(busy), 64'd0);
        chk("p2_idle_done", 64'(done), 64'd0);
        tick();
        chk("p3_restart_busy", 64'(busy), 64'd1);
        chk("p3_restart_rqst", 64'(rom_rqst), 64'd1);
        chk("p3_restart_addr", 64'(rom_addr), 64'd0);
        start = 1'b0;
        tick();
        tick();

        // Pass 3: abort with reset at row 50.
        run_stream(50, -1, -1);
        snap_done = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 64'(win_valid), 64'd0);
        chk("abort_rqst", 64'(rom_rqst), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_addr", 64'(rom_addr), 64'd0);
        chk("abort_row", 64'(win_row), 64'd0);
        chk("abort_above", win_above, 64'd0);
        chk("abort_center", win_center, 64'd0);
        chk("abort_below", win_below, 64'd0);
        repeat (3) tick();
        chk("abort_no_done", 64'(done_cnt - snap_done), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        // Fresh start reproduces window 0.
        start_pass();
        run_stream(0, -1, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // ROWS=2 instance.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("r2_prime_rqst", 64'(rom_rqst2), 64'd1);
        tick();
        tick();
        chk("r2_w0_valid", 64'(win_valid2), 64'd1);
        chk("r2_w0_row", 64'(win_row2), 64'd0);
        chk("r2_w0_above", win_above2, exp_above(0));
        chk("r2_w0_center", win_center2, rowv(0));
        chk("r2_w0_below", win_below2, rowv(1));
        chk("r2_w0_rqst", 64'(rom_rqst2), 64'd0);
        tick();
        chk("r2_w1_valid", 64'(win_valid2), 64'd1);
        chk("r2_w1_row", 64'(win_row2), 64'd1);
        chk("r2_w1_above", win_above2, rowv(0));
        chk("r2_w1_center", win_center2, rowv(1));
        chk("r2_w1_below", win_below2, exp_below(1, 2));
        tick();
        chk("r2_done", 64'(done2), 64'd1);
        chk("r2_done_valid", 64'(win_valid2), 64'd0);
        tick();
        chk("r2_done_low", 64'(done2), 64'd0);
        chk("r2_idle_busy", 64'(busy2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
